// File: rtl/pipe_hazard_ctrl.sv
// Scoreboard hazard and flush controller for a 5-stage in-order RV32I pipeline
// with no forwarding. Tracks in-flight destination registers from execute to
// write-back, stalls decode on RAW hazards, injects bubbles, and sequences
// front-end flushes after taken branches/jumps.
// Optional feature macro: HAZARD_PERF_EN (stall / redirect performance counters).
module pipe_hazard_ctrl #(
  parameter int unsigned DEPTH        = 3,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter bit          WB_BYPASS    = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        dec_valid_i,
  input  logic [4:0]  dec_rs1_addr_i,
  input  logic [4:0]  dec_rs2_addr_i,
  input  logic        dec_rs1_used_i,
  input  logic        dec_rs2_used_i,
  input  logic [4:0]  dec_rd_addr_i,
  input  logic        dec_rd_wr_i,
  input  logic        pipe_adv_i,
  input  logic        exec_redirect_i,
  output logic        dec_stall_o,
  output logic        ftch_flush_o,
  output logic        exec_flush_o,
  output logic [31:0] perf_stall_cnt_o,
  output logic [31:0] perf_flush_cnt_o
);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StFlush = 1'b1;

  // Counter reload value; unused when FLUSH_CYCLES is 0.
  localparam logic [2:0] FlushInit = (FLUSH_CYCLES > 0) ? 3'(FLUSH_CYCLES - 1) : 3'd0;

  logic [DEPTH-1:0] r_v;
  logic [4:0]       r_rd [DEPTH];
  logic [0:0]       r_state;
  logic [2:0]       r_cnt;

  logic w_rs1_hit;
  logic w_rs2_hit;
  logic w_hazard;
  logic w_flushing;
  logic w_issue;
  logic w_ins_v;

  // Scoreboard lookup; with write-through register file the write-back entry is skipped.
  always_comb begin
    w_rs1_hit = 1'b0;
    w_rs2_hit = 1'b0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (!(WB_BYPASS && (k == DEPTH - 1)) && r_v[k]) begin
        if (r_rd[k] == dec_rs1_addr_i) w_rs1_hit = 1'b1;
        if (r_rd[k] == dec_rs2_addr_i) w_rs2_hit = 1'b1;
      end
    end
  end

  assign w_hazard = dec_valid_i &&
                    ((dec_rs1_used_i && (dec_rs1_addr_i != 5'd0) && w_rs1_hit) ||
                     (dec_rs2_used_i && (dec_rs2_addr_i != 5'd0) && w_rs2_hit));

  assign w_flushing = exec_redirect_i || (r_state == StFlush);
  assign w_issue    = dec_valid_i && !w_hazard && !w_flushing && pipe_adv_i;
  // x0 writes never create a dependency.
  assign w_ins_v    = w_issue && dec_rd_wr_i && (dec_rd_addr_i != 5'd0);

  // Tracker shift register; holds completely while downstream is not ready.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_v <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        r_rd[k] <= 5'd0;
      end
    end else if (pipe_adv_i) begin
      for (int unsigned k = 1; k < DEPTH; k++) begin
        r_v[k]  <= r_v[k-1];
        r_rd[k] <= r_rd[k-1];
      end
      r_v[0]  <= w_ins_v;
      r_rd[0] <= dec_rd_addr_i;
    end
  end

  // Flush sequencer; a redirect in any state restarts the refill window.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= StIdle;
      r_cnt   <= 3'd0;
    end else if (exec_redirect_i) begin
      if (FLUSH_CYCLES > 0) begin
        r_state <= StFlush;
        r_cnt   <= FlushInit;
      end else begin
        r_state <= StIdle;
      end
    end else if (r_state == StFlush) begin
      if (r_cnt == 3'd0) begin
        r_state <= StIdle;
      end else begin
        r_cnt <= r_cnt - 3'd1;
      end
    end
  end

  // Pipeline control outputs; a redirect overrides any stall so the stale instruction drops.
  always_comb begin
    dec_stall_o  = 1'b0;
    ftch_flush_o = 1'b0;
    exec_flush_o = 1'b1;
    if (!rst_i) begin
      dec_stall_o  = (w_hazard || !pipe_adv_i) && !w_flushing;
      ftch_flush_o = exec_redirect_i;
      exec_flush_o = w_flushing || (w_hazard && pipe_adv_i);
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_flush;

  // Saturating performance counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_perf_stall <= 32'h0;
      r_perf_flush <= 32'h0;
    end else begin
      if (w_hazard && !w_flushing && (r_perf_stall != 32'hFFFF_FFFF)) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
      if (exec_redirect_i && (r_perf_flush != 32'hFFFF_FFFF)) begin
        r_perf_flush <= r_perf_flush + 32'd1;
      end
    end
  end

  assign perf_stall_cnt_o = r_perf_stall;
  assign perf_flush_cnt_o = r_perf_flush;
`else
  assign perf_stall_cnt_o = 32'h0;
  assign perf_flush_cnt_o = 32'h0;
`endif

endmodule
